// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and address-decode helpers for main_memory
package mem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;
   localparam int DEF_LINE_WIDTH = 128;
   localparam int DEF_INDEX_BITS = 8;
   localparam int OFFSET = $clog2(DEF_LINE_WIDTH / 8);
   localparam int LINES = 1 << DEF_INDEX_BITS;
   function automatic int offset_of(input int line_width);
      return $clog2(line_width / 8);
   endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: synchronous-write, combinational-read line storage (not reset)
module mem_array #(
   parameter int LINE_WIDTH = 128,
   parameter int INDEX_BITS = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] index,
   input  logic [LINE_WIDTH-1:0] wdata,
   output logic [LINE_WIDTH-1:0] rdata
);
   logic [LINE_WIDTH-1:0] mem [1 << INDEX_BITS];
   always_ff @(posedge clk)
      if (we) mem[index] <= wdata;
   always_comb rdata = mem[index];
endmodule

// File: rtl/main_memory.sv
// main_memory: backing-store responder serving line refills and writebacks
// after a fixed latency, one request at a time.
module main_memory
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128,
   parameter int INDEX_BITS = 8,
   parameter int LATENCY    = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LINE_WIDTH-1:0] req_data,
   output logic                  resp_valid,
   output logic [LINE_WIDTH-1:0] resp_data
);
   localparam int OFF = offset_of(LINE_WIDTH);
   localparam int CW  = $clog2(LATENCY + 1);
   mem_state_t state;
   logic [CW-1:0] cnt;
   logic lat_write, accept, we, unused_addr;
   logic [INDEX_BITS-1:0] lat_idx, req_idx, idx;
   logic [LINE_WIDTH-1:0] rdata;
   always_comb begin
      req_idx     = req_addr[OFF+INDEX_BITS-1:OFF];
      req_ready   = state == IDLE;
      accept      = req_valid && req_ready;
      we          = accept && req_write;
      idx         = req_ready ? req_idx : lat_idx;
      unused_addr = ^{req_addr[ADDR_WIDTH-1:OFF+INDEX_BITS], req_addr[OFF-1:0]};
   end
   mem_array #(.LINE_WIDTH(LINE_WIDTH), .INDEX_BITS(INDEX_BITS)) u_array (
      .clk   (clk),
      .we    (we),
      .index (idx),
      .wdata (req_data),
      .rdata (rdata)
   );
   // Writes commit on the acceptance edge, so only the kind and index are latched.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_write  <= 1'b0;
         lat_idx    <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         case (state)
            IDLE: if (accept) begin
               lat_write <= req_write;
               lat_idx   <= req_idx;
               cnt       <= CW'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_data  <= req_write ? '0 : rdata;
               end else state <= BUSY;
            end
            BUSY: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_data  <= lat_write ? '0 : rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed and randomized checks of main_memory at LATENCY 5 and 1
// against a line-array reference model.
module tb_main_memory;
   logic clk = 1'b0;
   logic rst_n;
   logic         req_valid  [2];
   logic         req_ready  [2];
   logic         req_write  [2];
   logic [31:0]  req_addr   [2];
   logic [127:0] req_data   [2];
   logic         resp_valid [2];
   logic [127:0] resp_data  [2];
   logic [127:0] model   [2][256];
   bit           written [2][256];
   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   main_memory #(.LATENCY(5)) u5 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
      .resp_valid(resp_valid[0]), .resp_data(resp_data[0])
   );
   main_memory #(.LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
      .resp_valid(resp_valid[1]), .resp_data(resp_data[1])
   );

   task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
   endtask

   // Issue one request, wait for acceptance, then check every cycle up to ready returning.
   task automatic do_req(input int d, input bit wr, input logic [31:0] addr, input logic [127:0] data);
      int n;
      int l;
      int idx;
      logic [127:0] exp;
      l = d ? 1 : 5;
      idx = int'((addr >> 4) & 32'hFF);
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_data[d]  = data;
      req_valid[d] = 1'b1;
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", d, n < 20, 1);
      if (wr) begin
         model[d][idx]   = data;
         written[d][idx] = 1'b1;
      end
      exp = wr ? 128'd0 : model[d][idx];
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      for (int k = 1; k <= l + 1; k++) begin
         @(negedge clk);
         chk("resp_valid", d, resp_valid[d], k == l);
         chk("req_ready", d, req_ready[d], k > l);
         if (k == l) chk("resp_data", d, resp_data[d], exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d1;
      logic [127:0] d2;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_write[d] = 1'b0;
         req_addr[d]  = '0;
         req_data[d]  = '0;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, req_ready[d], 1);
            chk("rst_valid", d, resp_valid[d], 0);
            chk("rst_data", d, resp_data[d], 0);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      d1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
      do_req(0, 1'b1, 32'h0000_0040, d1);
      do_req(0, 1'b0, 32'h0000_0040, '0);
      do_req(0, 1'b0, 32'h0000_104C, '0);
      d2 = {$urandom, $urandom, $urandom, $urandom};
      do_req(0, 1'b1, 32'h0000_0050, d2);
      do_req(0, 1'b0, 32'h0000_0040, '0);
      do_req(0, 1'b0, 32'h0000_0050, '0);
      // req_valid held high: accepts every 6 edges, pulse one cycle before each re-accept
      req_write[0] = 1'b0;
      req_addr[0]  = 32'h0000_0044;
      req_valid[0] = 1'b1;
      for (int n = 1; n <= 18; n++) begin
         @(negedge clk);
         chk("hold_ready", 0, req_ready[0], n % 6 == 0);
         chk("hold_valid", 0, resp_valid[0], n % 6 == 5);
         if (n % 6 == 5) chk("hold_data", 0, resp_data[0], model[0][4]);
      end
      req_valid[0] = 1'b0;
      do_req(1, 1'b1, 32'h0000_0000, d2);
      do_req(1, 1'b0, 32'h0000_0000, '0);
      do_req(1, 1'b0, 32'h00AB_C007, '0);
      // Reset while busy: no response, but the accepted write persists
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h0000_0020;
      req_data[0]  = d1 ^ d2;
      req_valid[0] = 1'b1;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      model[0][2]   = d1 ^ d2;
      written[0][2] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("midrst_valid", 0, resp_valid[0], 0);
         chk("midrst_ready", 0, req_ready[0], 1);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("post_rst_valid", 0, resp_valid[0], 0);
      end
      do_req(0, 1'b0, 32'h0000_3020, '0);
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 12; i++) begin
            int idx;
            bit wr;
            logic [31:0] a;
            idx = int'($urandom_range(0, 7));
            wr  = !written[d][idx] || ($urandom_range(0, 1) == 1);
            a   = ($urandom & 32'hFFFF_F00F) | (32'(idx) << 4);
            do_req(d, wr, a, {$urandom, $urandom, $urandom, $urandom});
         end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
